// File: rtl/sa_feeder_if.sv
// Purpose : bundles the weight/activation handshakes and the array-side buses of sa_feeder.
// Latency : n/a (wiring only).
// Backpressure: wt_in_ready / act_in_ready are owned by the feeder (slave side).
//
// Ports (slave view):
//   start                         tile request, honoured only when the feeder is idle
//   wt_in_valid/ready/data        one weight row per beat, slice c -> column c
//   act_in_valid/ready/data/last  one activation vector per beat, slice r -> row r
//   wt_row_en, wt_out             weight-load enables (one-hot per row) and column weight bus
//   a_out, a_valid                skewed activations and per-row valids into column 0
//   busy, done                    tile in progress / one-cycle completion pulse
interface sa_feeder_if #(
    parameter int N         = 4,
    parameter int DATAWIDTH = 8
);
    logic                     start;
    logic                     wt_in_valid;
    logic                     wt_in_ready;
    logic [N*DATAWIDTH-1:0]   wt_in_data;
    logic                     act_in_valid;
    logic                     act_in_ready;
    logic [N*DATAWIDTH-1:0]   act_in_data;
    logic                     act_in_last;
    logic [N-1:0]             wt_row_en;
    logic [N*DATAWIDTH-1:0]   wt_out;
    logic [N*DATAWIDTH-1:0]   a_out;
    logic [N-1:0]             a_valid;
    logic                     busy;
    logic                     done;

    modport master (
        output start, wt_in_valid, wt_in_data, act_in_valid, act_in_data, act_in_last,
        input  wt_in_ready, act_in_ready, wt_row_en, wt_out, a_out, a_valid, busy, done
    );

    modport slave (
        input  start, wt_in_valid, wt_in_data, act_in_valid, act_in_data, act_in_last,
        output wt_in_ready, act_in_ready, wt_row_en, wt_out, a_out, a_valid, busy, done
    );
endinterface

// File: rtl/sa_feeder.sv
// Purpose : loads N weight rows into a systolic array, then streams activation vectors with a per-row skew.
// Latency : weight row visible 1 cycle after accept; activation slice r visible 1+r cycles after accept; done N cycles after the last vector.
// Backpressure: accepts weights only in LOAD_W and activations only in STREAM; idle cycles in STREAM become bubbles.
//
// Ports:
//   clk, rst  rising-edge clock, synchronous active-high reset
//   bus       sa_feeder_if.slave (handshakes in, array buses and status out)
module sa_feeder #(
    parameter int N         = 4,
    parameter int DATAWIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    sa_feeder_if.slave  bus
);
    localparam int RW = $clog2(N);
    localparam int W  = N * DATAWIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [RW-1:0]  row_cnt;
    logic           wt_xfer;
    logic           act_xfer;
    logic           last_xfer;
    logic           last_out;
    logic [N-1:0]   wt_row_en_q;
    logic [W-1:0]   wt_out_q;
    logic [N-1:0]   last_sr;
    logic [W-1:0]   a_out_w;
    logic [N-1:0]   a_valid_w;

    assign wt_xfer   = bus.wt_in_valid  & bus.wt_in_ready;
    assign act_xfer  = bus.act_in_valid & bus.act_in_ready;
    assign last_xfer = act_xfer & bus.act_in_last;
    // The last flag leaves the delay line in the same cycle the final
    // vector's row N-1 element leaves the skew line.
    assign last_out  = last_sr[N-1];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = LOAD_W;
                end
            end
            LOAD_W: begin
                if (wt_xfer && (row_cnt == RW'(N - 1))) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (last_xfer) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_out) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the current state
    // ------------------------------------------------------------------
    always_comb begin
        bus.wt_in_ready  = 1'b0;
        bus.act_in_ready = 1'b0;
        bus.busy         = 1'b0;
        case (state)
            LOAD_W: begin
                bus.wt_in_ready = 1'b1;
                bus.busy        = 1'b1;
            end
            STREAM: begin
                bus.act_in_ready = 1'b1;
                bus.busy         = 1'b1;
            end
            DRAIN: begin
                bus.busy = 1'b1;
            end
            default: ;
        endcase
        bus.done = last_out;
    end

    // ------------------------------------------------------------------
    // Weight row counter and registered weight bus
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
        end else if (state == IDLE) begin
            row_cnt <= '0;
        end else if (wt_xfer) begin
            row_cnt <= (row_cnt == RW'(N - 1)) ? '0 : row_cnt + 1'b1;
        end
    end

    // wt_row_en is a single-cycle strobe; wt_out keeps the last row so the
    // column wires stay quiet between beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            wt_row_en_q <= '0;
            wt_out_q    <= '0;
        end else begin
            wt_row_en_q <= '0;
            if (wt_xfer) begin
                wt_row_en_q <= N'(1) << row_cnt;
                wt_out_q    <= bus.wt_in_data;
            end
        end
    end

    assign bus.wt_row_en = wt_row_en_q;
    assign bus.wt_out    = wt_out_q;

    // ------------------------------------------------------------------
    // Last-flag delay line, same depth as the row N-1 skew line
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            last_sr <= '0;
        end else begin
            last_sr <= {last_sr[N-2:0], last_xfer};
        end
    end

    // ------------------------------------------------------------------
    // Activation skew: row r is a shift line of r+1 registers. Bubbles and
    // drain cycles load zero data with valid low, so a_out is zero whenever
    // a_valid is low without any output gating.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < N; r++) begin : g_row
        logic [DATAWIDTH-1:0] d_sr [0:r];
        logic [r:0]           v_sr;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= r; k++) begin
                    d_sr[k] <= '0;
                end
                v_sr <= '0;
            end else begin
                d_sr[0] <= act_xfer ? bus.act_in_data[r*DATAWIDTH +: DATAWIDTH] : '0;
                v_sr[0] <= act_xfer;
                for (int k = 1; k <= r; k++) begin
                    d_sr[k] <= d_sr[k-1];
                    v_sr[k] <= v_sr[k-1];
                end
            end
        end

        assign a_out_w[r*DATAWIDTH +: DATAWIDTH] = d_sr[r];
        assign a_valid_w[r]                      = v_sr[r];

        a_zero_when_idle: assert property (@(posedge clk) disable iff (rst)
            !v_sr[r] |-> (d_sr[r] == '0));
    end

    assign bus.a_out   = a_out_w;
    assign bus.a_valid = a_valid_w;

    a_wt_en_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(wt_row_en_q));

endmodule

// File: tb/tb_sa_feeder.sv
// Purpose : self-checking bench for sa_feeder: directed tile scenarios plus randomized tiles against a reference model.
// Latency : n/a.
// Backpressure: bench drives planned per-cycle stimulus; readies are checked, not waited on.
module tb_sa_feeder;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int W   = N * DW;
    localparam int CAP = 64;

    logic clk = 1'b0;
    logic rst;

    sa_feeder_if #(.N(N), .DATAWIDTH(DW)) bus ();
    sa_feeder #(.N(N), .DATAWIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // per-cycle stimulus plan
    logic         in_start [CAP];
    logic         in_rst   [CAP];
    logic         in_wv    [CAP];
    logic         in_av    [CAP];
    logic         in_al    [CAP];
    logic [W-1:0] in_wd    [CAP];
    logic [W-1:0] in_ad    [CAP];
    // observed trace
    logic         tr_wrdy [CAP];
    logic         tr_ardy [CAP];
    logic         tr_busy [CAP];
    logic         tr_done [CAP];
    logic [N-1:0] tr_wen  [CAP];
    logic [N-1:0] tr_av   [CAP];
    logic [W-1:0] tr_wout [CAP];
    logic [W-1:0] tr_ao   [CAP];
    // model expectations
    logic         exp_wrdy [CAP];
    logic         exp_ardy [CAP];
    logic         exp_busy [CAP];
    logic         exp_done [CAP];
    logic [N-1:0] exp_wen  [CAP];
    logic [N-1:0] exp_av   [CAP];
    logic [W-1:0] exp_wout [CAP];
    logic [W-1:0] exp_ao   [CAP];

    int           wgap [N];
    logic [W-1:0] wdat [N];
    logic [W-1:0] m_wout;

    task automatic drive_idle();
        bus.start        = 1'b0;
        bus.wt_in_valid  = 1'b0;
        bus.wt_in_data   = '0;
        bus.act_in_valid = 1'b0;
        bus.act_in_data  = '0;
        bus.act_in_last  = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        m_wout = '0;
    endtask

    task automatic clear_plan();
        for (int k = 0; k < CAP; k++) begin
            in_start[k] = 1'b0;
            in_rst[k]   = 1'b0;
            in_wv[k]    = 1'b0;
            in_av[k]    = 1'b0;
            in_al[k]    = 1'($urandom_range(0, 1));
            in_wd[k]    = W'($urandom);
            in_ad[k]    = W'($urandom);
        end
    endtask

    // start in cycle 0, weight beat b after wgap[b] idle cycles; returns first stream cycle
    task automatic plan_weights(output int s0);
        int k;
        k = 1;
        in_start[0] = 1'b1;
        for (int b = 0; b < N; b++) begin
            k = k + wgap[b];
            in_wv[k] = 1'b1;
            in_wd[k] = wdat[b];
            k++;
        end
        s0 = k;
    endtask

    // entered and left at posedge+1; outputs sampled on the falling edge
    task automatic run_tile(input int cap);
        for (int k = 0; k < cap; k++) begin
            rst              = in_rst[k];
            bus.start        = in_start[k];
            bus.wt_in_valid  = in_wv[k];
            bus.wt_in_data   = in_wd[k];
            bus.act_in_valid = in_av[k];
            bus.act_in_data  = in_ad[k];
            bus.act_in_last  = in_al[k];
            @(negedge clk);
            tr_wrdy[k] = bus.wt_in_ready;
            tr_ardy[k] = bus.act_in_ready;
            tr_busy[k] = bus.busy;
            tr_done[k] = bus.done;
            tr_wen[k]  = bus.wt_row_en;
            tr_av[k]   = bus.a_valid;
            tr_wout[k] = bus.wt_out;
            tr_ao[k]   = bus.a_out;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        drive_idle();
    endtask

    // Reference: walk the tile phases; each accepted item schedules its outputs
    // at accept+1 (weights) or accept+1+r (activation row r); done at last+N.
    task automatic model_tile(input int cap);
        int ph;
        int ph_n;
        int row;
        int done_k;
        ph = 0; row = 0; done_k = -1;
        for (int k = 0; k < CAP; k++) begin
            exp_wen[k] = '0; exp_av[k] = '0; exp_ao[k] = '0; exp_done[k] = 1'b0;
        end
        for (int k = 0; k < cap; k++) begin
            ph_n        = ph;
            exp_busy[k] = (ph != 0);
            exp_wrdy[k] = (ph == 1);
            exp_ardy[k] = (ph == 2);
            exp_wout[k] = m_wout;
            exp_done[k] = (k == done_k);
            case (ph)
                0: if (in_start[k]) begin ph_n = 1; row = 0; end
                1: if (in_wv[k]) begin
                    if (k + 1 < CAP) exp_wen[k+1] = N'(1) << row;
                    m_wout = in_wd[k];
                    if (row == N - 1) ph_n = 2;
                    row++;
                end
                2: if (in_av[k]) begin
                    for (int r = 0; r < N; r++) begin
                        if (k + 1 + r < CAP) begin
                            exp_av[k+1+r][r]         = 1'b1;
                            exp_ao[k+1+r][r*DW +: DW] = in_ad[k][r*DW +: DW];
                        end
                    end
                    if (in_al[k]) begin ph_n = 3; done_k = k + N; end
                end
                default: if (k == done_k) ph_n = 0;
            endcase
            ph = ph_n;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (bus.wt_in_ready !== 1'b0)  begin bad++; $display("FAIL reset wt_in_ready got %b exp 0", bus.wt_in_ready); end
        total++; if (bus.act_in_ready !== 1'b0) begin bad++; $display("FAIL reset act_in_ready got %b exp 0", bus.act_in_ready); end
        total++; if (bus.wt_row_en !== '0)      begin bad++; $display("FAIL reset wt_row_en got %h exp 0", bus.wt_row_en); end
        total++; if (bus.wt_out !== '0)         begin bad++; $display("FAIL reset wt_out got %h exp 0", bus.wt_out); end
        total++; if (bus.a_out !== '0)          begin bad++; $display("FAIL reset a_out got %h exp 0", bus.a_out); end
        total++; if (bus.a_valid !== '0)        begin bad++; $display("FAIL reset a_valid got %h exp 0", bus.a_valid); end
        total++; if (bus.busy !== 1'b0)         begin bad++; $display("FAIL reset busy got %b exp 0", bus.busy); end
        total++; if (bus.done !== 1'b0)         begin bad++; $display("FAIL reset done got %b exp 0", bus.done); end
        @(posedge clk);
        #1;
    endtask

    // Directed tile: runs from whatever IDLE state the previous task left.
    task automatic test_basic_tile();
        int s0;
        clear_plan();
        wdat[0] = 32'h04030201; wdat[1] = 32'h08070605; wdat[2] = 32'h0C0B0A09; wdat[3] = 32'h100F0E0D;
        for (int b = 0; b < N; b++) wgap[b] = 0;
        plan_weights(s0);
        in_av[s0]   = 1'b1; in_ad[s0]   = 32'h44332211; in_al[s0]   = 1'b0;
        in_av[s0+1] = 1'b1; in_ad[s0+1] = 32'h88776655; in_al[s0+1] = 1'b1;
        run_tile(s0 + 9);
        for (int b = 0; b < N; b++) begin
            total++; if (tr_wen[2+b] !== N'(1 << b)) begin bad++; $display("FAIL basic wt_row_en beat %0d got %b exp %b", b, tr_wen[2+b], N'(1 << b)); end
            total++; if (tr_wout[2+b] !== wdat[b])   begin bad++; $display("FAIL basic wt_out beat %0d got %h exp %h", b, tr_wout[2+b], wdat[b]); end
        end
        total++; if (tr_wen[1] !== '0)       begin bad++; $display("FAIL basic wt_row_en early got %b exp 0", tr_wen[1]); end
        total++; if (tr_wen[6] !== '0)       begin bad++; $display("FAIL basic wt_row_en late got %b exp 0", tr_wen[6]); end
        total++; if (tr_ardy[s0] !== 1'b1)   begin bad++; $display("FAIL basic act_in_ready got %b exp 1", tr_ardy[s0]); end
        total++; if (tr_wrdy[s0] !== 1'b0)   begin bad++; $display("FAIL basic wt_in_ready in stream got %b exp 0", tr_wrdy[s0]); end
        total++; if (tr_av[s0+1][0] !== 1'b1 || tr_ao[s0+1][7:0] !== 8'h11) begin bad++; $display("FAIL basic row0 first got v=%b d=%h exp v=1 d=11", tr_av[s0+1][0], tr_ao[s0+1][7:0]); end
        total++; if (tr_av[s0+2][0] !== 1'b1 || tr_ao[s0+2][7:0] !== 8'h55) begin bad++; $display("FAIL basic row0 second got v=%b d=%h exp v=1 d=55", tr_av[s0+2][0], tr_ao[s0+2][7:0]); end
        total++; if (tr_av[s0+4][3] !== 1'b1 || tr_ao[s0+4][31:24] !== 8'h44) begin bad++; $display("FAIL basic row3 first got v=%b d=%h exp v=1 d=44", tr_av[s0+4][3], tr_ao[s0+4][31:24]); end
        total++; if (tr_av[s0+5][3] !== 1'b1 || tr_ao[s0+5][31:24] !== 8'h88) begin bad++; $display("FAIL basic row3 second got v=%b d=%h exp v=1 d=88", tr_av[s0+5][3], tr_ao[s0+5][31:24]); end
        total++; if (tr_done[s0+4] !== 1'b0) begin bad++; $display("FAIL basic done early got %b exp 0", tr_done[s0+4]); end
        total++; if (tr_done[s0+5] !== 1'b1) begin bad++; $display("FAIL basic done got %b exp 1", tr_done[s0+5]); end
        total++; if (tr_busy[s0+5] !== 1'b1) begin bad++; $display("FAIL basic busy at done got %b exp 1", tr_busy[s0+5]); end
        total++; if (tr_busy[s0+6] !== 1'b0) begin bad++; $display("FAIL basic busy after done got %b exp 0", tr_busy[s0+6]); end
    endtask

    task automatic test_weight_gaps();
        int s0;
        logic [N-1:0] e;
        do_reset();
        clear_plan();
        for (int b = 0; b < N; b++) begin wgap[b] = 2; wdat[b] = W'($urandom); end
        plan_weights(s0);
        in_av[s0] = 1'b1; in_al[s0] = 1'b1;
        run_tile(s0 + N + 3);
        // beat b accepted at cycle 3+3b, so its strobe lands at 4+3b
        for (int k = 1; k <= s0 + 2; k++) begin
            e = (k >= 4 && k <= 13 && (k - 4) % 3 == 0) ? N'(1 << ((k - 4) / 3)) : '0;
            total++; if (tr_wen[k] !== e) begin bad++; $display("FAIL gaps wt_row_en cyc %0d got %b exp %b", k, tr_wen[k], e); end
        end
        total++; if (tr_wout[5] !== wdat[0])  begin bad++; $display("FAIL gaps wt_out hold got %h exp %h", tr_wout[5], wdat[0]); end
        total++; if (tr_wout[6] !== wdat[0])  begin bad++; $display("FAIL gaps wt_out hold2 got %h exp %h", tr_wout[6], wdat[0]); end
        total++; if (tr_wout[14] !== wdat[3]) begin bad++; $display("FAIL gaps wt_out last got %h exp %h", tr_wout[14], wdat[3]); end
        total++; if (tr_done[s0+N] !== 1'b1)  begin bad++; $display("FAIL gaps done got %b exp 1", tr_done[s0+N]); end
    endtask

    task automatic test_bubble();
        int s0;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        do_reset();
        clear_plan();
        for (int b = 0; b < N; b++) begin wgap[b] = 0; wdat[b] = W'($urandom); end
        plan_weights(s0);
        va = W'($urandom); vb = W'($urandom);
        in_av[s0]   = 1'b1; in_ad[s0]   = va; in_al[s0]   = 1'b0;
        in_av[s0+1] = 1'b0;                   in_al[s0+1] = 1'b1;
        in_av[s0+2] = 1'b1; in_ad[s0+2] = vb; in_al[s0+2] = 1'b1;
        run_tile(s0 + 10);
        for (int r = 0; r < N; r++) begin
            total++; if (tr_av[s0+1+r][r] !== 1'b1)                  begin bad++; $display("FAIL bubble row%0d v1 got %b exp 1", r, tr_av[s0+1+r][r]); end
            total++; if (tr_ao[s0+1+r][r*DW +: DW] !== va[r*DW +: DW]) begin bad++; $display("FAIL bubble row%0d d1 got %h exp %h", r, tr_ao[s0+1+r][r*DW +: DW], va[r*DW +: DW]); end
            total++; if (tr_av[s0+2+r][r] !== 1'b0)                  begin bad++; $display("FAIL bubble row%0d v2 got %b exp 0", r, tr_av[s0+2+r][r]); end
            total++; if (tr_ao[s0+2+r][r*DW +: DW] !== '0)           begin bad++; $display("FAIL bubble row%0d d2 got %h exp 0", r, tr_ao[s0+2+r][r*DW +: DW]); end
            total++; if (tr_av[s0+3+r][r] !== 1'b1)                  begin bad++; $display("FAIL bubble row%0d v3 got %b exp 1", r, tr_av[s0+3+r][r]); end
            total++; if (tr_ao[s0+3+r][r*DW +: DW] !== vb[r*DW +: DW]) begin bad++; $display("FAIL bubble row%0d d3 got %h exp %h", r, tr_ao[s0+3+r][r*DW +: DW], vb[r*DW +: DW]); end
        end
        total++; if (tr_done[s0+5] !== 1'b0) begin bad++; $display("FAIL bubble done early got %b exp 0", tr_done[s0+5]); end
        total++; if (tr_done[s0+6] !== 1'b1) begin bad++; $display("FAIL bubble done got %b exp 1", tr_done[s0+6]); end
    endtask

    task automatic test_start_ignored();
        int s0;
        do_reset();
        clear_plan();
        for (int b = 0; b < N; b++) begin wgap[b] = 0; wdat[b] = W'($urandom); end
        plan_weights(s0);
        in_start[2] = 1'b1; in_start[3] = 1'b1; in_start[s0] = 1'b1;
        in_av[s0+1] = 1'b1; in_al[s0+1] = 1'b1;
        in_start[s0+5] = 1'b1;    // done cycle: still DRAIN
        in_start[s0+6] = 1'b1;    // IDLE: honoured
        run_tile(s0 + 9);
        total++; if (tr_wen[s0] !== N'(1 << (N - 1))) begin bad++; $display("FAIL start row order got %b exp %b", tr_wen[s0], N'(1 << (N - 1))); end
        total++; if (tr_wrdy[s0] !== 1'b0)   begin bad++; $display("FAIL start wt_in_ready in stream got %b exp 0", tr_wrdy[s0]); end
        total++; if (tr_ardy[s0+1] !== 1'b1) begin bad++; $display("FAIL start act_in_ready got %b exp 1", tr_ardy[s0+1]); end
        total++; if (tr_ao[s0+2][DW-1:0] !== in_ad[s0+1][DW-1:0]) begin bad++; $display("FAIL start row0 data got %h exp %h", tr_ao[s0+2][DW-1:0], in_ad[s0+1][DW-1:0]); end
        total++; if (tr_done[s0+4] !== 1'b0) begin bad++; $display("FAIL start done early got %b exp 0", tr_done[s0+4]); end
        total++; if (tr_done[s0+5] !== 1'b1) begin bad++; $display("FAIL start done got %b exp 1", tr_done[s0+5]); end
        total++; if (tr_busy[s0+6] !== 1'b0) begin bad++; $display("FAIL start busy after done got %b exp 0", tr_busy[s0+6]); end
        total++; if (tr_busy[s0+7] !== 1'b1) begin bad++; $display("FAIL start restart busy got %b exp 1", tr_busy[s0+7]); end
        total++; if (tr_wrdy[s0+7] !== 1'b1) begin bad++; $display("FAIL start restart wt_in_ready got %b exp 1", tr_wrdy[s0+7]); end
    endtask

    task automatic test_reset_midstream();
        int s0;
        do_reset();
        clear_plan();
        for (int b = 0; b < N; b++) begin wgap[b] = 0; wdat[b] = W'($urandom) | 32'h1; end
        plan_weights(s0);
        for (int j = 0; j < 3; j++) begin in_av[s0+j] = 1'b1; in_al[s0+j] = 1'b0; in_ad[s0+j] = W'($urandom) | 32'h01010101; end
        in_rst[s0+3] = 1'b1;
        run_tile(s0 + 11);
        total++; if (tr_wrdy[s0+4] !== 1'b0) begin bad++; $display("FAIL rstmid wt_in_ready got %b exp 0", tr_wrdy[s0+4]); end
        total++; if (tr_ardy[s0+4] !== 1'b0) begin bad++; $display("FAIL rstmid act_in_ready got %b exp 0", tr_ardy[s0+4]); end
        total++; if (tr_wen[s0+4] !== '0)    begin bad++; $display("FAIL rstmid wt_row_en got %b exp 0", tr_wen[s0+4]); end
        total++; if (tr_wout[s0+4] !== '0)   begin bad++; $display("FAIL rstmid wt_out got %h exp 0", tr_wout[s0+4]); end
        for (int k = s0 + 4; k < s0 + 11; k++) begin
            total++; if (tr_av[k] !== '0 || tr_ao[k] !== '0) begin bad++; $display("FAIL rstmid skew cyc %0d got v=%b d=%h exp 0", k, tr_av[k], tr_ao[k]); end
            total++; if (tr_done[k] !== 1'b0 || tr_busy[k] !== 1'b0) begin bad++; $display("FAIL rstmid status cyc %0d got done=%b busy=%b exp 0", k, tr_done[k], tr_busy[k]); end
        end
        test_basic_tile();
    endtask

    task automatic test_random_tiles();
        int s0;
        int sl;
        int cap;
        do_reset();
        for (int t = 0; t < 6; t++) begin
            clear_plan();
            for (int b = 0; b < N; b++) begin wgap[b] = $urandom_range(0, 2); wdat[b] = W'($urandom); end
            plan_weights(s0);
            sl  = $urandom_range(1, 8);
            cap = s0 + sl + N + 2;
            for (int k = 1; k < s0; k++) in_av[k] = 1'($urandom_range(0, 1));
            for (int j = 0; j < sl; j++) begin
                in_av[s0+j] = (j == sl - 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (in_av[s0+j]) in_al[s0+j] = (j == sl - 1);
                in_wv[s0+j] = 1'($urandom_range(0, 1));
            end
            for (int k = s0 + sl; k < cap; k++) begin
                in_av[k] = 1'($urandom_range(0, 1));
                in_wv[k] = 1'($urandom_range(0, 1));
            end
            for (int k = 1; k < s0 + sl; k++) if ($urandom_range(0, 4) == 0) in_start[k] = 1'b1;
            model_tile(cap);
            run_tile(cap);
            for (int k = 0; k < cap; k++) begin
                total++; if (tr_wrdy[k] !== exp_wrdy[k]) begin bad++; $display("FAIL rand%0d wt_in_ready cyc %0d got %b exp %b", t, k, tr_wrdy[k], exp_wrdy[k]); end
                total++; if (tr_ardy[k] !== exp_ardy[k]) begin bad++; $display("FAIL rand%0d act_in_ready cyc %0d got %b exp %b", t, k, tr_ardy[k], exp_ardy[k]); end
                total++; if (tr_busy[k] !== exp_busy[k]) begin bad++; $display("FAIL rand%0d busy cyc %0d got %b exp %b", t, k, tr_busy[k], exp_busy[k]); end
                total++; if (tr_done[k] !== exp_done[k]) begin bad++; $display("FAIL rand%0d done cyc %0d got %b exp %b", t, k, tr_done[k], exp_done[k]); end
                total++; if (tr_wen[k] !== exp_wen[k])   begin bad++; $display("FAIL rand%0d wt_row_en cyc %0d got %b exp %b", t, k, tr_wen[k], exp_wen[k]); end
                total++; if (tr_wout[k] !== exp_wout[k]) begin bad++; $display("FAIL rand%0d wt_out cyc %0d got %h exp %h", t, k, tr_wout[k], exp_wout[k]); end
                total++; if (tr_av[k] !== exp_av[k])     begin bad++; $display("FAIL rand%0d a_valid cyc %0d got %b exp %b", t, k, tr_av[k], exp_av[k]); end
                total++; if (tr_ao[k] !== exp_ao[k])     begin bad++; $display("FAIL rand%0d a_out cyc %0d got %h exp %h", t, k, tr_ao[k], exp_ao[k]); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_basic_tile();
        test_weight_gaps();
        test_bubble();
        test_start_ignored();
        test_reset_midstream();
        test_random_tiles();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sa_feeder.md
SA_FEEDER -- requirements
Module: sa_feeder

Interface
REQ-001 Parameter N, default 4, meaning array dimension (rows = columns = N), N >= 2.
REQ-002 Parameter DATAWIDTH, default 8, meaning width of one weight and one activation element.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin one tile (weight load then stream); honoured only in IDLE.
REQ-006 wt_in_valid / wt_in_ready  input / output  1 / 1  weight-row handshake; transfer when both high.
REQ-007 wt_in_data  input  N*DATAWIDTH  one weight row; slice c (bits c*DATAWIDTH+:DATAWIDTH) targets column c.
REQ-008 act_in_valid / act_in_ready  input / output  1 / 1  activation-vector handshake; transfer when both high.
REQ-009 act_in_data  input  N*DATAWIDTH  one activation vector; slice r targets array row r.
REQ-010 act_in_last  input  1  qualifies the final vector of the tile; sampled only on transfer.
REQ-011 wt_row_en  output  N  one-hot weight-load enable; bit r drives wt_en of every PE in row r.
REQ-012 wt_out  output  N*DATAWIDTH  weight bus; slice c drives wt of every PE in column c.
REQ-013 a_out  output  N*DATAWIDTH  skewed activations; slice r drives in_A of PE(r,0).
REQ-014 a_valid  output  N  bit r drives valid_in of row r, aligned with a_out slice r.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse marking tile completion.

Function
REQ-017 States IDLE, LOAD_W, STREAM, DRAIN; IDLE -> LOAD_W on start; all other start pulses ignored.
REQ-018 LOAD_W: wt_in_ready=1, act_in_ready=0; row counter 0..N-1 advances per accepted beat; accepting beat N-1 -> STREAM.
REQ-019 Weight beat accepted at cycle t with row counter r: wt_row_en = one-hot(r) and wt_out = wt_in_data at cycle t+1; wt_row_en = 0 in every other cycle.
REQ-020 wt_out holds its last value when wt_row_en = 0.
REQ-021 STREAM: act_in_ready=1, wt_in_ready=0; a transfer with act_in_last=1 -> DRAIN.
REQ-022 Vector accepted at cycle t: slice r appears on a_out slice r with a_valid[r]=1 at cycle t+1+r (row 0 one register, row r r extra registers).
REQ-023 A STREAM cycle without transfer inserts a bubble: the corresponding skew slots carry valid 0 and data 0.
REQ-024 a_out slice r is 0 whenever a_valid[r]=0.
REQ-025 DRAIN: both readies 0; the skew pipeline continues to shift; remains until the last-tagged vector exits row N-1.
REQ-026 done = 1 in the cycle a_valid[N-1] carries the element of the act_in_last vector; next state IDLE.
REQ-027 A last flag travels with each vector through a delay line matching row N-1 so that done alignment holds despite bubbles.
REQ-028 Vectors accepted before the last one still emerge normally during DRAIN; no element is dropped or duplicated.
REQ-029 A tile with a single vector (act_in_last on first transfer) is legal: done at t+N.
REQ-030 Back-to-back start after done: start in the cycle done is high is ignored (state is still DRAIN); start in the next cycle is honoured.

Reset
REQ-031 rst (sampled high at a clock edge) forces state IDLE, row counter 0, all skew/last registers 0.
REQ-032 Output reset values: wt_in_ready=0, act_in_ready=0, wt_row_en=0, wt_out=0, a_out=0, a_valid=0, busy=0, done=0.
REQ-033 Reset mid-LOAD_W, mid-STREAM or mid-DRAIN discards all in-flight data; no done pulse is produced for the aborted tile.

Verification
REQ-034 N=4: start, 4 weight beats 0x04030201,0x08070605,0x0C0B0A09,0x100F0E0D back-to-back -> wt_row_en 0001,0010,0100,1000 on consecutive cycles with matching wt_out, then act_in_ready=1.
REQ-035 Weight beats with wt_in_valid gaps of 2 cycles -> wt_row_en pulses only on accept+1, no extra pulses, row order unchanged.
REQ-036 Stream vectors 0x44332211 (t), 0x88776655 (t+1, last) -> row0 0x11@t+1,0x55@t+2; row3 0x44@t+4,0x88@t+5; done@t+5; busy low @t+6.
REQ-037 Vector at t, bubble at t+1, last vector at t+2 -> each row shows valid,0,valid pattern with a_out=0 in bubble; done at t+2+4.
REQ-038 Assert rst during STREAM with 3 vectors in flight -> next cycle all outputs zero, state IDLE, no done; subsequent full tile behaves as REQ-034/036.
REQ-039 start asserted during LOAD_W and during STREAM -> ignored; single-vector tile -> done at accept+4.
